lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
Memory-access stage placed directly downstream of the execute stage and upstream of writeback. It accepts one executed instruction per valid/ready handshake and performs at most one load or store on a single-channel memory bus. Loads are aligned and sign- or zero-extended, and stores are shifted with byte strobes generated. Misaligned accesses and bus errors are flagged. Results and sideband control are registered and handed to writeback, and the stage also supplies a forwarding port.

Parameters:
REGS_DIG, 5, register-index width
CSR_DIG, 12, CSR-address width
WORD_T, 32, datapath width (fixed at 32; not overridable in practice)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute stage has an instruction
in_ready  out  1  stage can accept
in_result  in  32  ALU result; address for load/store
in_wdata  in  32  store data
in_lsu_read  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6/7 treated as none
in_lsu_write  in  2  0 none, 1 SB, 2 SH, 3 SW
in_pc  in  32  instruction PC
in_rd  in  REGS_DIG  destination register
in_reg_write, in_csr_write, in_ecall, in_mret, in_ebreak, in_fence_i  in  1 each  sideband controls
in_csr_addr  in  CSR_DIG  CSR address
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_req_wen  out  1  1 for store
mem_req_wdata  out  32  shifted store data
mem_req_wstrb  out  4  byte strobes (0 on loads)
mem_rsp_valid  in  1  response present
mem_rsp_ready  out  1  stage accepts response
mem_rsp_rdata  in  32  read word
mem_rsp_err  in  1  access fault
out_valid  out  1  result for writeback
out_ready  in  1  writeback accepts
out_data  out  32  load data or passed-through result
out_pc, out_rd, out_reg_write, out_csr_write, out_csr_addr, out_ecall, out_mret, out_ebreak, out_fence_i  out  as inputs  registered sideband
out_load_misaligned, out_store_misaligned, out_access_fault  out  1 each  exception flags
fwd_valid  out  1  out_valid && out_reg_write
fwd_rd  out  REGS_DIG  equals out_rd
fwd_data  out  32  equals out_data

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (async, rst_n=0) forces IDLE.
- Reset values: all outputs 0, with in_ready=1 in IDLE. All registered fields clear to 0.
- Acceptance: in_ready = (state==IDLE) || (state==DONE && out_ready). A transfer occurs when in_valid && in_ready, and all inputs are captured on that edge.
- Captured non-memory op (read none, write none): next state DONE. out_data = in_result. out_valid rises the cycle after acceptance.
- Captured LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0: no bus request. Go to DONE with out_load_misaligned or out_store_misaligned set and out_data = address.
- Captured valid memory op: next state REQ. mem_req_valid=1 from the next cycle.
- If both a read and a write are encoded, the read wins.
- REQ: the request is held stable while mem_req_valid && !mem_req_ready. On the handshake, go to WAIT and drop mem_req_valid the next cycle.
- WAIT: mem_rsp_ready=1. A response is never expected in the same cycle as the request handshake. On mem_rsp_valid, go to DONE.
  - Load: out_data = extend(rdata >> 8*addr[1:0]). LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Store: out_data = address.
  - mem_rsp_err=1 sets out_access_fault.
- Store encoding:
  - wdata = in_wdata << 8*addr[1:0].
  - wstrb: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
- DONE: out_valid=1 and all out_* are held stable until out_ready.
  - out_ready with a new in_valid: capture the new instruction on the same edge (back-to-back).
  - out_ready without a new in_valid: go to IDLE.
- Exception flags are valid only while out_valid=1 and are cleared on the next capture.
- mem_rsp_valid outside WAIT is ignored.
- Reset mid-transaction: the stage drops to IDLE immediately. The outstanding request or response is abandoned, and the bus side tolerates this.
- Throughput: non-memory ops 1 per cycle when out_ready is held 1. Loads/stores take a minimum of 3 cycles from acceptance to out_valid with zero-wait bus.

Test Plan:
- ADD pass-through: in_result=0x1234, reg_write=1, rd=5, out_ready=1 -> out_valid next cycle, out_data=0x1234, fwd_valid=1, fwd_rd=5; 4 consecutive ops -> 4 outputs on 4 consecutive cycles.
- LB at addr 0x80000003, rdata=0x80FF_0000 -> req_addr=0x80000000, wstrb=0, out_data=0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x...2, rdata=0xBEEF0000 -> 0x0000BEEF.
- SH at 0x80000102, wdata=0x0000ABCD, mem_req_ready low 3 cycles -> request stable 4 cycles, wdata=0xABCD0000, wstrb=4'b1100, wen=1.
- LW at 0x80000001 -> no mem_req_valid, out_load_misaligned=1, out_data=0x80000001; SW at 0x...2 -> out_store_misaligned=1.
- LW with mem_rsp_err=1 -> out_access_fault=1; out_ready=0 for 5 cycles -> out_* stable, in_ready=0.
- rst_n pulled low in WAIT -> all outputs 0 asynchronously; late mem_rsp_valid after reset produces no out_valid.

Source files
------------

// File: rtl/lsu_mem_stage.sv
//==============================================================================
// Module      : lsu_mem_stage
// Description : Memory-access pipeline stage between execute and writeback.
//               Performs at most one aligned load or store per instruction on
//               a single-channel request/response bus. It extends load data,
//               shifts store data and builds byte strobes. It also flags
//               misaligned accesses and bus faults, and drives a forwarding
//               port from the registered result.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu_mem_stage #(
  parameter int REGS_DIG = 5,
  parameter int CSR_DIG  = 12,
  parameter int WORD_T   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // execute-side handshake
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_T-1:0]   in_result,
  input  logic [WORD_T-1:0]   in_wdata,
  input  logic [2:0]          in_lsu_read,
  input  logic [1:0]          in_lsu_write,
  input  logic [WORD_T-1:0]   in_pc,
  input  logic [REGS_DIG-1:0] in_rd,
  input  logic                in_reg_write,
  input  logic                in_csr_write,
  input  logic [CSR_DIG-1:0]  in_csr_addr,
  input  logic                in_ecall,
  input  logic                in_mret,
  input  logic                in_ebreak,
  input  logic                in_fence_i,
  // memory bus
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [WORD_T-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [WORD_T-1:0]   mem_req_wdata,
  output logic [3:0]          mem_req_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [WORD_T-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err,
  // writeback-side handshake
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_T-1:0]   out_data,
  output logic [WORD_T-1:0]   out_pc,
  output logic [REGS_DIG-1:0] out_rd,
  output logic                out_reg_write,
  output logic                out_csr_write,
  output logic [CSR_DIG-1:0]  out_csr_addr,
  output logic                out_ecall,
  output logic                out_mret,
  output logic                out_ebreak,
  output logic                out_fence_i,
  output logic                out_load_misaligned,
  output logic                out_store_misaligned,
  output logic                out_access_fault,
  // forwarding
  output logic                fwd_valid,
  output logic [REGS_DIG-1:0] fwd_rd,
  output logic [WORD_T-1:0]   fwd_data
);

  localparam logic [2:0] c_LB  = 3'd1;
  localparam logic [2:0] c_LBU = 3'd2;
  localparam logic [2:0] c_LH  = 3'd3;
  localparam logic [2:0] c_LHU = 3'd4;
  localparam logic [2:0] c_LW  = 3'd5;
  localparam logic [1:0] c_SB  = 2'd1;
  localparam logic [1:0] c_SH  = 2'd2;
  localparam logic [1:0] c_SW  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_lsu_read;   // load type of the op in flight, 0 for none
  logic [1:0]          r_off;        // byte offset within the word
  logic [WORD_T-3:0]   r_word_addr;
  logic                r_wen;
  logic [WORD_T-1:0]   r_wdata;
  logic [3:0]          r_wstrb;
  logic [WORD_T-1:0]   r_out_data;
  logic [WORD_T-1:0]   r_out_pc;
  logic [REGS_DIG-1:0] r_out_rd;
  logic                r_out_reg_write;
  logic                r_out_csr_write;
  logic [CSR_DIG-1:0]  r_out_csr_addr;
  logic                r_out_ecall;
  logic                r_out_mret;
  logic                r_out_ebreak;
  logic                r_out_fence_i;
  logic                r_load_mis;
  logic                r_store_mis;
  logic                r_fault;

  logic                w_accept;
  logic                w_is_read;
  logic                w_is_write;
  logic                w_mis_ld;
  logic                w_mis_st;
  logic [WORD_T-1:0]   w_st_wdata;
  logic [3:0]          w_st_wstrb;
  logic [WORD_T-1:0]   w_rsp_shift;
  logic [WORD_T-1:0]   w_ld_data;

  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;

  // a read encoding takes priority over a simultaneous write encoding
  assign w_is_read  = (in_lsu_read >= c_LB) && (in_lsu_read <= c_LW);
  assign w_is_write = !w_is_read && (in_lsu_write != 2'd0);

  assign w_mis_ld = w_is_read &&
                    ((((in_lsu_read == c_LH) || (in_lsu_read == c_LHU)) && in_result[0]) ||
                     ((in_lsu_read == c_LW) && (in_result[1:0] != 2'b00)));
  assign w_mis_st = w_is_write &&
                    (((in_lsu_write == c_SH) && in_result[0]) ||
                     ((in_lsu_write == c_SW) && (in_result[1:0] != 2'b00)));

  assign w_st_wdata  = in_wdata << {in_result[1:0], 3'b000};
  assign w_rsp_shift = mem_rsp_rdata >> {r_off, 3'b000};

  // store byte strobes for the captured write type and offset
  always_comb begin
    w_st_wstrb = 4'b0000;
    if (w_is_write) begin
      case (in_lsu_write)
        c_SB:    w_st_wstrb = 4'b0001 << in_result[1:0];
        c_SH:    w_st_wstrb = 4'b0011 << in_result[1:0];
        c_SW:    w_st_wstrb = 4'b1111;
        default: w_st_wstrb = 4'b0000;
      endcase
    end
  end

  // sign/zero extension of the aligned response word
  always_comb begin
    w_ld_data = w_rsp_shift;
    case (r_lsu_read)
      c_LB:    w_ld_data = {{(WORD_T-8){w_rsp_shift[7]}}, w_rsp_shift[7:0]};
      c_LBU:   w_ld_data = {{(WORD_T-8){1'b0}}, w_rsp_shift[7:0]};
      c_LH:    w_ld_data = {{(WORD_T-16){w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      c_LHU:   w_ld_data = {{(WORD_T-16){1'b0}}, w_rsp_shift[15:0]};
      default: w_ld_data = w_rsp_shift;
    endcase
  end

  // stage FSM: capture, bus request, response wait, hold result for writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_lsu_read      <= 3'd0;
      r_off           <= 2'd0;
      r_word_addr     <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wstrb         <= 4'b0000;
      r_out_data      <= '0;
      r_out_pc        <= '0;
      r_out_rd        <= '0;
      r_out_reg_write <= 1'b0;
      r_out_csr_write <= 1'b0;
      r_out_csr_addr  <= '0;
      r_out_ecall     <= 1'b0;
      r_out_mret      <= 1'b0;
      r_out_ebreak    <= 1'b0;
      r_out_fence_i   <= 1'b0;
      r_load_mis      <= 1'b0;
      r_store_mis     <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_lsu_read      <= w_is_read ? in_lsu_read : 3'd0;
            r_off           <= in_result[1:0];
            r_word_addr     <= in_result[WORD_T-1:2];
            r_wen           <= w_is_write;
            r_wdata         <= w_is_write ? w_st_wdata : '0;
            r_wstrb         <= w_st_wstrb;
            r_out_data      <= in_result;
            r_out_pc        <= in_pc;
            r_out_rd        <= in_rd;
            r_out_reg_write <= in_reg_write;
            r_out_csr_write <= in_csr_write;
            r_out_csr_addr  <= in_csr_addr;
            r_out_ecall     <= in_ecall;
            r_out_mret      <= in_mret;
            r_out_ebreak    <= in_ebreak;
            r_out_fence_i   <= in_fence_i;
            r_load_mis      <= w_mis_ld;
            r_store_mis     <= w_mis_st;
            r_fault         <= 1'b0;
            if ((w_is_read || w_is_write) && !w_mis_ld && !w_mis_st)
              r_state <= ST_REQ;
            else
              r_state <= ST_DONE;
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_req_ready)
            r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            // stores keep the address as their result
            if (r_lsu_read != 3'd0)
              r_out_data <= w_ld_data;
            r_fault <= mem_rsp_err;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = {r_word_addr, 2'b00};
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;
  assign mem_rsp_ready = (r_state == ST_WAIT);

  assign out_valid            = (r_state == ST_DONE);
  assign out_data             = r_out_data;
  assign out_pc               = r_out_pc;
  assign out_rd               = r_out_rd;
  assign out_reg_write        = r_out_reg_write;
  assign out_csr_write        = r_out_csr_write;
  assign out_csr_addr         = r_out_csr_addr;
  assign out_ecall            = r_out_ecall;
  assign out_mret             = r_out_mret;
  assign out_ebreak           = r_out_ebreak;
  assign out_fence_i          = r_out_fence_i;
  assign out_load_misaligned  = r_load_mis;
  assign out_store_misaligned = r_store_mis;
  assign out_access_fault     = r_fault;

  assign fwd_valid = out_valid && r_out_reg_write;
  assign fwd_rd    = r_out_rd;
  assign fwd_data  = r_out_data;

endmodule

`default_nettype wire
